// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
// Contents: the FSM state type, the LFSR seed and feedback mask, the BCD
// value shown for an early press, and two helper functions (LFSR step and
// integer-to-BCD conversion for elaboration-time constants).
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    TIMING,
    DONE,
    EARLY,
    TIMEOUT
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // One step of the right-shifting Galois LFSR. The mask is a maximal-length
  // polynomial, so a non-zero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Four-digit BCD encoding of a small integer, used for constants only.
  function automatic logic [15:0] to_bcd(input int unsigned n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit synchronous BCD up-counter.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears the count
//   clr  in   synchronous clear
//   inc  in   add one to the count (decimal carry between digits)
//   q    out  {thousands, hundreds, tens, ones}, 4 bits per digit
// The count wraps 9999 -> 0000.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  logic [15:0] q_next;
  logic        carry;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    q_next = q;
    carry  = inc;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_next[4*i +: 4] = 4'd0;
        end else begin
          q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/reaction_sequencer.sv
// Control FSM for the reaction-timer game:
//   arm -> random wait -> stimulus LED -> millisecond timing -> result.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   start         in   1-cycle pulse, arm a trial
//   stop          in   1-cycle pulse, player reaction
//   clear         in   1-cycle pulse, abort or acknowledge, back to idle
//   stim_led      out  stimulus lamp, high only while timing
//   bcd           out  result digits {thou, hund, tens, ones}
//   busy          out  high while waiting or timing
//   result_valid  out  high when a result (done/early/timeout) is shown
//   early         out  stop was pressed before the stimulus
//   timeout       out  no stop within TIMEOUT_MS
// Input priority within one cycle: rst > clear > stop > start > tick.
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int TICK_DIV    = 100_000,
  parameter int MIN_WAIT_MS = 2000,
  parameter int RAND_BITS   = 13,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        stim_led,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
);

  localparam int WAIT_W = $clog2(MIN_WAIT_MS + 2 ** RAND_BITS);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // The count that the next tick turns into TIMEOUT_MS.
  localparam logic [15:0] TIMEOUT_LAST = to_bcd(TIMEOUT_MS - 1);

  state_t              state, state_next;
  logic [PRE_W-1:0]    presc;
  logic                tick;
  logic [15:0]         lfsr;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [15:0]         cnt_q;
  logic                cnt_inc, cnt_clr;
  logic                phase_entry;

  assign tick = (presc == PRE_W'(TICK_DIV - 1));

  // The prescaler restarts whenever a timed phase begins, so the first tick
  // of WAIT or TIMING lands exactly TICK_DIV cycles after entry.
  assign phase_entry = ((state_next == WAIT)   && (state != WAIT)) ||
                       ((state_next == TIMING) && (state != TIMING));

  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    if (clear) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_next = WAIT;
        end
        WAIT: begin
          // stop beats the expiring tick in the same cycle.
          if (stop) begin
            state_next = EARLY;
          end else if (tick && (wait_cnt == WAIT_W'(1))) begin
            state_next = TIMING;
            cnt_clr    = 1'b1;
          end
        end
        TIMING: begin
          // A tick coinciding with stop is discarded: the count freezes.
          if (stop) begin
            state_next = DONE;
          end else if (tick) begin
            cnt_inc = 1'b1;
            if (cnt_q == TIMEOUT_LAST) state_next = TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      presc        <= '0;
      wait_cnt     <= '0;
      stim_led     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      early        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_step(lfsr);

      if (phase_entry || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PRE_W'(1);
      end

      if ((state == IDLE) && (state_next == WAIT)) begin
        wait_cnt <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[RAND_BITS-1:0]);
      end else if ((state == WAIT) && (state_next == WAIT) && tick) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end

      // Flags are registered from the next state so they move together with it.
      stim_led     <= (state_next == TIMING);
      busy         <= (state_next == WAIT) || (state_next == TIMING);
      result_valid <= (state_next == DONE) || (state_next == EARLY) ||
                      (state_next == TIMEOUT);
      early        <= (state_next == EARLY);
      timeout      <= (state_next == TIMEOUT);
    end
  end

  bcd_counter4 u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (cnt_q)
  );

  // The counter sits at zero throughout WAIT and EARLY, so the early flag
  // (itself a flop) substitutes the all-nines marker without a load path.
  assign bcd = early ? BCD_MAX : cnt_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer with small timing parameters.
// Trials push their expected result into a queue when armed; a monitor pops
// and compares whenever result_valid rises.
module tb_reaction_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int MIN_WAIT_MS = 3;
  localparam int RAND_BITS   = 2;
  localparam int TIMEOUT_MS  = 12;
  localparam int TIMEOUT_CYC = TIMEOUT_MS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        stim_led;
  logic [15:0] bcd;
  logic        busy;
  logic        result_valid;
  logic        early;
  logic        timeout;

  always #5 clk = ~clk;

  reaction_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .MIN_WAIT_MS (MIN_WAIT_MS),
    .RAND_BITS   (RAND_BITS),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .stim_led     (stim_led),
    .bcd          (bcd),
    .busy         (busy),
    .result_valid (result_valid),
    .early        (early),
    .timeout      (timeout)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        early;
    logic        timeout;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference random source: the LFSR sequence as a plain value stepped once
  // per clock, reseeded by rst.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
  end

  function automatic logic [15:0] dec_to_bcd(input int n);
    return 16'((n / 1000) % 10 * 4096 + (n / 100) % 10 * 256 + (n / 10) % 10 * 16 + n % 10);
  endfunction

  // Monitor: a result appearing is compared against the oldest expectation.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got bcd %0h with none expected (t=%0t)", bcd, $time);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_bcd"},     bcd,      e.bcd);
        check({e.tag, "_early"},   early,    e.early);
        check({e.tag, "_timeout"}, timeout,  e.timeout);
        check({e.tag, "_led"},     stim_led, 1'b0);
        check({e.tag, "_busy"},    busy,     1'b0);
      end
    end
    rv_prev = result_valid;
  end

  // Drive inputs at a falling edge; they are sampled on the next rising edge
  // and released at the following falling edge.
  task automatic pulse(input logic s, input logic p, input logic c, input logic r);
    start = s; stop = p; clear = c; rst = r;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  // Arm a trial and check the random wait lasts exactly the modelled ticks.
  task automatic arm(input string tag);
    int wait_ticks;
    int cycles;
    wait_ticks = MIN_WAIT_MS + int'(m_lfsr % (2 ** RAND_BITS));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, "_busy_wait"}, busy, 1'b1);
    cycles = 0;
    while (stim_led !== 1'b1 && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_wait_cycles"}, cycles, wait_ticks * TICK_DIV);
  endtask

  task automatic await_result(input string tag);
    int n;
    n = 0;
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_result_seen"}, result_valid, 1'b1);
  endtask

  task automatic ack(input string tag);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, "_clr_bcd"}, bcd, 16'h0000);
    check({tag, "_clr_rv"},  result_valid, 1'b0);
  endtask

  // d = rising edge after stimulus on which stop is sampled; 0 = never.
  task automatic timing_trial(input string tag, input int d);
    exp_t e;
    logic done;
    done      = (d > 0) && (d <= TIMEOUT_CYC);
    e.tag     = tag;
    e.early   = 1'b0;
    e.timeout = !done;
    e.bcd     = done ? dec_to_bcd((d - 1) / TICK_DIV) : dec_to_bcd(TIMEOUT_MS);
    exp_q.push_back(e);
    arm(tag);
    if (d > 0) begin
      repeat (d - 1) @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
    end
    await_result(tag);
    if (done) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check({tag, "_start_in_done_bcd"}, bcd, e.bcd);
      check({tag, "_start_in_done_rv"},  result_valid, 1'b1);
      check({tag, "_start_in_done_busy"}, busy, 1'b0);
    end
    ack(tag);
  endtask

  // d = rising edge after arming on which stop is sampled (within the wait).
  task automatic early_trial(input string tag, input int d);
    exp_t e;
    int   led_seen;
    e.tag     = tag;
    e.bcd     = 16'h9999;
    e.early   = 1'b1;
    e.timeout = 1'b0;
    exp_q.push_back(e);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    led_seen = 0;
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      if (stim_led === 1'b1) led_seen++;
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    await_result(tag);
    check({tag, "_led_never"}, led_seen, 0);
    ack(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_bcd",  bcd,          16'h0000);
    check("reset_led",  stim_led,     1'b0);
    check("reset_busy", busy,         1'b0);
    check("reset_rv",   result_valid, 1'b0);
    check("reset_flags", {early, timeout}, 2'b00);

    // stop ignored in IDLE
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_stop_busy", busy, 1'b0);
    check("idle_stop_rv",   result_valid, 1'b0);

    timing_trial("normal5", 5 * TICK_DIV + 1);
    idle_gap();
    early_trial("early2", 2);
    idle_gap();
    timing_trial("timeout", 0);
    idle_gap();
    timing_trial("collide7", 8 * TICK_DIV);
    idle_gap();
    timing_trial("collide_last", TIMEOUT_CYC);
    idle_gap();

    // stop on the very tick that would end the wait still counts as early
    wt = MIN_WAIT_MS + int'(m_lfsr % (2 ** RAND_BITS));
    early_trial("early_edge", wt * TICK_DIV);
    idle_gap();

    // clear together with stop while timing -> idle, no result
    arm("clr_stop");
    repeat ($urandom_range(1, 20)) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_stop_bcd",  bcd,          16'h0000);
    check("clr_stop_busy", busy,         1'b0);
    check("clr_stop_led",  stim_led,     1'b0);
    check("clr_stop_rv",   result_valid, 1'b0);
    idle_gap();

    // reset in the middle of timing at count 3
    arm("rst_mid");
    repeat (3 * TICK_DIV + 1) @(negedge clk);
    check("rst_mid_pre_bcd", bcd, 16'h0003);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_bcd",  bcd,      16'h0000);
    check("rst_mid_busy", busy,     1'b0);
    check("rst_mid_led",  stim_led, 1'b0);
    idle_gap();

    // randomized trials
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        wt = MIN_WAIT_MS + int'(m_lfsr % (2 ** RAND_BITS));
        early_trial($sformatf("rand_early%0d", t), int'($urandom_range(1, wt * TICK_DIV)));
      end else begin
        d = int'($urandom_range(0, TIMEOUT_CYC + 8));
        timing_trial($sformatf("rand_time%0d", t), d);
      end
      idle_gap();
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
